// File: rtl/string_match_engine.sv
// string_match_engine
//   Streaming string matcher. A string of up to STR_MAX chars is loaded byte-serially, then one
//   or more patterns of up to PAT_MAX chars. Each pattern is searched against the stored string
//   one start position per cycle. A one-cycle valid strobe reports match and the lowest index.
//   Pattern metacharacters: leading '^', trailing '$', and '.' as a single-char wildcard.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous active-low reset
//   chardata     in   8      character, sampled while isstring or ispattern is high
//   isstring     in   1      chardata is the next string char
//   ispattern    in   1      chardata is the next pattern char
//   valid        out  1      one-cycle result strobe
//   match        out  1      pattern found (zero outside valid)
//   match_index  out  IDX_W  index of the first char matched by the non-'^' part (zero outside valid)
//
// Configuration
//   SME_CASE_FOLD_EN  when defined, plain-char compare ignores ASCII letter case.

module string_match_engine #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned IDX_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index
);

    localparam int unsigned LW  = IDX_W + 1;          // string length / extended position width
    localparam int unsigned PW  = $clog2(PAT_MAX + 1);
    localparam int unsigned PIW = $clog2(PAT_MAX);

    typedef enum logic [2:0] {StIdle, StLoadS, StLoadP, StSearch, StDone} state_t;

    state_t           state_q, state_d;
    logic [7:0]       str_q [STR_MAX];
    logic [7:0]       pat_q [PAT_MAX];
    logic [LW-1:0]    str_len_q;
    logic [PW-1:0]    pat_len_q;
    logic             str_stale_q;   // next string char starts a fresh string
    logic [IDX_W-1:0] pos_q;
    logic             match_q;
    logic [IDX_W-1:0] index_q;

    function automatic logic [7:0] fold(input logic [7:0] c);
        logic [7:0] r;
        r = c;
`ifdef SME_CASE_FOLD_EN
        if (c >= 8'h61 && c <= 8'h7A) begin
            r = c - 8'h20;
        end
`else
`endif
        return r;
    endfunction

    // Pattern decode and parallel compare at start position pos_q
    logic          has_caret, has_dollar, body_ok, caret_ok, dollar_ok, hit;
    logic [PW-1:0] body_len;
    logic [LW-1:0] end_pos, sidx;
    logic [PIW-1:0] pidx;
    logic [7:0]    pc;

    always_comb begin
        has_caret  = (pat_len_q != '0) && (pat_q[0] == 8'h5E);
        has_dollar = (pat_len_q > PW'(has_caret)) &&
                     (pat_q[PIW'(pat_len_q - PW'(1))] == 8'h24);
        body_len   = pat_len_q - PW'(has_caret) - PW'(has_dollar);
        body_ok    = 1'b1;
        sidx       = '0;
        pidx       = '0;
        pc         = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < int'(body_len)) begin
                sidx = LW'(pos_q) + LW'(i);
                pidx = PIW'(i) + PIW'(has_caret);
                pc   = pat_q[pidx];
                if (sidx >= str_len_q) begin
                    body_ok = 1'b0;
                end else if (pc != 8'h2E &&
                             fold(str_q[IDX_W'(sidx)]) != fold(pc)) begin
                    body_ok = 1'b0;
                end
            end
        end
        end_pos   = LW'(pos_q) + LW'(body_len);
        // Anchor on a space consumes it: the space sits just outside the body
        caret_ok  = !has_caret || (pos_q == '0) || (str_q[pos_q - IDX_W'(1)] == 8'h20);
        dollar_ok = !has_dollar || (end_pos == str_len_q) ||
                    ((end_pos < str_len_q) && (str_q[IDX_W'(end_pos)] == 8'h20));
        // A pure-anchor pattern has no body and matches at 0
        hit = (body_len == '0) ? (pos_q == '0) : (body_ok && caret_ok && dollar_ok);
    end

    logic search_last;
    assign search_last = (str_len_q == '0) || ({1'b0, pos_q} == str_len_q - LW'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (isstring) begin
                    state_d = StLoadS;
                end else if (ispattern) begin
                    state_d = StLoadP;
                end
            end
            StLoadS: begin
                if (ispattern) begin
                    state_d = StLoadP;
                end else if (!isstring) begin
                    state_d = StIdle;
                end
            end
            StLoadP: begin
                if (!ispattern) begin
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (search_last || hit) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    logic accept;
    logic str_we, pat_we;
    logic [IDX_W-1:0] str_waddr;
    logic [PIW-1:0]   pat_waddr;

    always_comb begin
        accept    = (state_q == StIdle) || (state_q == StLoadS) || (state_q == StLoadP);
        str_we    = accept && isstring && (str_stale_q || (str_len_q < LW'(STR_MAX)));
        str_waddr = str_stale_q ? '0 : IDX_W'(str_len_q);
        pat_we    = accept && ispattern &&
                    ((state_q != StLoadP) || (pat_len_q < PW'(PAT_MAX)));
        pat_waddr = (state_q != StLoadP) ? '0 : PIW'(pat_len_q);
    end

    // Character storage needs no reset; lengths gate every read
    always_ff @(posedge clk) begin
        if (str_we) begin
            str_q[str_waddr] <= chardata;
        end
        if (pat_we) begin
            pat_q[pat_waddr] <= chardata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            str_len_q   <= '0;
            pat_len_q   <= '0;
            str_stale_q <= 1'b0;
            pos_q       <= '0;
            match_q     <= 1'b0;
            index_q     <= '0;
        end else begin
            state_q <= state_d;
            if (str_we) begin
                str_len_q   <= str_stale_q ? LW'(1) : str_len_q + LW'(1);
                str_stale_q <= 1'b0;
            end
            if (accept && ispattern) begin
                str_stale_q <= 1'b1;
            end
            if (pat_we) begin
                pat_len_q <= (state_q != StLoadP) ? PW'(1) : pat_len_q + PW'(1);
            end
            if (state_q == StLoadP && !ispattern) begin
                pos_q   <= '0;
                match_q <= 1'b0;
                index_q <= '0;
            end
            if (state_q == StSearch) begin
                if (hit && str_len_q != '0) begin
                    match_q <= 1'b1;
                    index_q <= pos_q;
                end else begin
                    pos_q <= pos_q + IDX_W'(1);
                end
            end
            if (state_q == StDone) begin
                str_stale_q <= 1'b1;
            end
        end
    end

    assign valid       = (state_q == StDone);
    assign match       = valid && match_q;
    assign match_index = valid ? index_q : '0;

endmodule

// File: tb/tb_string_match_engine.sv
module tb_string_match_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] chardata = 8'h00;
    logic       isstring = 1'b0;
    logic       ispattern = 1'b0;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    string_match_engine dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [63:0] pat;
        int          len;
        logic        exp_match;
        int          exp_idx;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic send(input logic [7:0] c, input bit is_s);
        @(negedge clk);
        chardata  = c;
        isstring  = is_s;
        ispattern = ~is_s;
    endtask

    task automatic idle_in();
        @(negedge clk);
        chardata  = 8'h00;
        isstring  = 1'b0;
        ispattern = 1'b0;
    endtask

    task automatic load_str(input logic [255:0] s, input int n);
        for (int i = 0; i < n; i++) send(s[8*(n-1-i) +: 8], 1'b1);
        idle_in();
    endtask

    task automatic send_pat(input logic [63:0] p, input int n);
        for (int i = 0; i < n; i++) send(p[8*(n-1-i) +: 8], 1'b0);
        idle_in();
    endtask

    task automatic run_pat(input string name, input logic [63:0] p, input int n,
                           input bit em, input int ei, output int lat);
        bit got   = 1'b0;
        bit quiet = 1'b1;
        send_pat(p, n);
        lat = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (valid) begin
                got = 1'b1;
                check({name, " match"}, int'(match), int'(em));
                if (em) check({name, " index"}, int'(match_index), ei);
            end else if (match || match_index != 5'd0) begin
                quiet = 1'b0;
            end
        end
        check({name, " valid"}, int'(got), 1);
        check({name, " quiet"}, int'(quiet), 1);
        if (got) begin
            @(negedge clk);
            check({name, " pulse"}, int'(valid), 0);
        end
    endtask

    initial begin
        int   lat;
        logic seen;

        vecs[0]  = '{"BOOK",   4, 1'b1, 10};
        vecs[1]  = '{"^IS",    3, 1'b1, 5};
        vecs[2]  = '{"^TH",    3, 1'b1, 0};
        vecs[3]  = '{"IS$",    3, 1'b1, 2};
        vecs[4]  = '{"OK$",    3, 1'b1, 12};
        vecs[5]  = '{"S.I",    3, 1'b1, 3};
        vecs[6]  = '{"CAT",    3, 1'b0, 0};
        vecs[7]  = '{"^",      1, 1'b1, 0};
        vecs[8]  = '{"$",      1, 1'b1, 0};
        vecs[9]  = '{"BOOKS",  5, 1'b0, 0};
        vecs[10] = '{"^BOOK$", 6, 1'b1, 10};
        vecs[11] = '{"A B",    3, 1'b1, 8};
        vecs[12] = '{"K$",     2, 1'b1, 13};
`ifdef SME_CASE_FOLD_EN
        vecs[13] = '{"book",   4, 1'b1, 10};
`else
        vecs[13] = '{"book",   4, 1'b0, 0};
`endif

        repeat (2) @(negedge clk);
        check("reset valid", int'(valid), 0);
        check("reset match", int'(match), 0);
        check("reset index", int'(match_index), 0);
        reset = 1'b1;
        idle_in();

        load_str("THIS IS A BOOK", 14);
        for (int i = 0; i < 14; i++) begin
            run_pat($sformatf("vec%0d", i), vecs[i].pat, vecs[i].len,
                    vecs[i].exp_match, vecs[i].exp_idx, lat);
        end

        load_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ012345", 32);
        run_pat("long 2345", "2345", 4, 1'b1, 28, lat);
        run_pat("long miss", "ZZ", 2, 1'b0, 0, lat);
        check("long latency ok", int'(lat <= 35), 1);

        load_str("XY", 2);
        run_pat("xy XY", "XY", 2, 1'b1, 0, lat);
        run_pat("xy Y$", "Y$", 2, 1'b1, 1, lat);
        run_pat("xy cleared", "2", 1, 1'b0, 0, lat);

        // Reset during a long search aborts it without a result
        load_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ012345", 32);
        send_pat("ZZ", 2);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort valid", int'(valid), 0);
        check("abort match", int'(match), 0);
        check("abort index", int'(match_index), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        check("abort no valid", int'(seen), 0);

        // String length cleared by reset: nothing can match
        run_pat("empty str", "A", 1, 1'b0, 0, lat);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
